symbol_encoder: RTL and testbench
=================================

SYMBOL_ENCODER -- requirements
Module: symbol_encoder

Interface
REQ-001 SHALL have parameter ESC_CODE, default 8'hFF: reserved escape code; the table entry at this address never matches.
REQ-002 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port sym_valid  in  1  input symbol offered.
REQ-005 SHALL have port sym_ready  out  1  encoder accepts a symbol.
REQ-006 SHALL have port sym_data  in  16  symbol to encode.
REQ-007 SHALL have port code_valid  out  1  output code beat valid.
REQ-008 SHALL have port code_ready  in  1  downstream accepts the beat.
REQ-009 SHALL have port code_data  out  8  output code beat.
REQ-010 SHALL have port code_last  out  1  final beat of the current symbol's encoding.
REQ-011 SHALL have ports tbl_wr_en (in, 1), tbl_wr_addr (in, 8) and tbl_wr_data (in, 16): table write, code -> symbol.
REQ-012 SHALL have port tbl_wr_ack  out  1  one-cycle pulse, the cycle after a write took effect.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL hold a 256-entry table of 16-bit symbols, each entry with a valid bit.
REQ-015 SHALL take a table write only when busy=0 and tbl_wr_addr!=ESC_CODE.
- A taken write sets the entry and its valid bit, then pulses tbl_wr_ack.
- Other writes are dropped with no ack.
REQ-016 SHALL use FSM states IDLE, SEARCH, EMIT_CODE, EMIT_ESC, EMIT_HI and EMIT_LO.
REQ-017 SHALL drive sym_ready=1 only in IDLE.
- A symbol is accepted when sym_valid and sym_ready are both high.
- Acceptance latches sym_data, clears the index to 0 and moves to SEARCH.
REQ-018 SHALL, in SEARCH, compare one entry per cycle at index 0,1,2,...
- The first (lowest-index) valid entry equal to the latched symbol is the hit; its index moves to EMIT_CODE.
- No hit through index ESC_CODE-1 moves to EMIT_ESC.
REQ-019 SHALL, for a hit at index k, raise code_valid k+2 cycles after the acceptance edge.
- A miss raises code_valid 256 cycles after acceptance with the default ESC_CODE.
REQ-020 SHALL emit beats as follows:
- EMIT_CODE: code_data=k, code_last=1.
- EMIT_ESC: code_data=ESC_CODE, code_last=0.
- EMIT_HI: code_data=sym[15:8], code_last=0.
- EMIT_LO: code_data=sym[7:0], code_last=1.
REQ-021 SHALL advance a beat only on code_valid and code_ready; the last beat returns to IDLE.
REQ-022 SHALL hold code_data and code_last stable while code_valid=1 and code_ready=0.
REQ-023 SHALL drive code_valid=1 only in the EMIT_* states.
REQ-024 SHALL, when a write and a symbol arrive in the same IDLE cycle, take both; the search then sees the new entry.

Reset
REQ-025 SHALL, on reset, go to IDLE and clear all table valid bits, the cache and the index.
- Output values: sym_ready=0 during reset and 1 after; code_valid=0, code_data=0, code_last=0, tbl_wr_ack=0, busy=0.
REQ-026 SHALL, on reset mid-search or mid-emit, drop the in-flight symbol with no further beats.

Configuration
REQ-027 SHALL, when SYMENC_LAST_HIT_CACHE_EN is defined, keep a one-entry cache (symbol, code, valid).
- The cache loads on every SEARCH hit.
- Any taken table write invalidates it.
- An accepted symbol that hits the cache goes straight to EMIT_CODE, so code_valid rises 1 cycle after acceptance.
REQ-028 SHALL, without SYMENC_LAST_HIT_CACHE_EN, have no cache logic; every symbol goes through SEARCH.

Structure
REQ-029 SHALL put in package symbol_codec_pkg: SYM_W=16, CODE_W=8, the ESC_CODE default, and the FSM state typedef.
REQ-030 SHALL put storage, valid bits, write port and indexed read port in sub-module symbol_table; the FSM stays in symbol_encoder.

Verification
REQ-031 Write 0x00->0x1234 and 0x05->0xBEEF, then send 0xBEEF -> single beat 0x05, code_last=1, valid 7 cycles after acceptance.
REQ-032 Send unmapped 0xCAFE -> beats 0xFF, 0xCA, 0xFE with code_last on beat 3 only; first beat 256 cycles after acceptance.
REQ-033 Map 0x1234 at both 0x03 and 0x10 -> code 0x03; a write to 0xFF gives no tbl_wr_ack and 0xFFFF still escapes.
REQ-034 Hold code_ready=0 for 5 cycles during the escape sequence -> beat held stable, no beat lost or duplicated.
REQ-035 Assert reset during SEARCH for 0x1234 -> no beats; table empty afterwards, so 0x1234 then escapes.
REQ-036 With SYMENC_LAST_HIT_CACHE_EN, send 0xBEEF twice -> second code_valid 1 cycle after acceptance; after any table write it falls back to search latency.

Source files
------------

// File: rtl/symbol_codec_pkg.sv
// Shared widths, the default escape code and the encoder FSM state type
// for the symbol encoder.
package symbol_codec_pkg;

  localparam int SYM_W     = 16;
  localparam int CODE_W    = 8;
  localparam int TBL_DEPTH = 1 << CODE_W;

  localparam logic [CODE_W-1:0] ESC_CODE_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEARCH    = 3'd1,
    EMIT_CODE = 3'd2,
    EMIT_ESC  = 3'd3,
    EMIT_HI   = 3'd4,
    EMIT_LO   = 3'd5
  } enc_state_t;

endpackage

// File: rtl/symbol_table.sv
// Code -> symbol table: block-RAM style data array with registered read,
// plus a per-entry valid vector that is cleared by reset.
module symbol_table
  import symbol_codec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] wr_addr,
  input  logic [SYM_W-1:0]  wr_data,
  input  logic [CODE_W-1:0] rd_addr,
  output logic [SYM_W-1:0]  rd_data,
  output logic              rd_valid
);

  logic [SYM_W-1:0]     mem [TBL_DEPTH];
  logic [TBL_DEPTH-1:0] valid_bits_reg;
  logic [TBL_DEPTH-1:0] valid_set;
  logic [SYM_W-1:0]     rd_data_reg;
  logic                 rd_valid_reg;

  // Data array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  generate
    for (genvar gi = 0; gi < TBL_DEPTH; gi++) begin : g_valid_set
      assign valid_set[gi] = wr_en && (wr_addr == CODE_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits_reg <= '0;
      rd_valid_reg   <= 1'b0;
    end else begin
      valid_bits_reg <= valid_bits_reg | valid_set;
      rd_valid_reg   <= valid_bits_reg[rd_addr];
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/symbol_encoder.sv
// Symbol encoder: linear table search emitting a one-byte code or an escape
// sequence. Optional last-hit cache enabled by SYMENC_LAST_HIT_CACHE_EN.
module symbol_encoder
  import symbol_codec_pkg::*;
#(
  parameter logic [CODE_W-1:0] ESC_CODE = ESC_CODE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [SYM_W-1:0]  sym_data,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code_data,
  output logic              code_last,
  input  logic              tbl_wr_en,
  input  logic [CODE_W-1:0] tbl_wr_addr,
  input  logic [SYM_W-1:0]  tbl_wr_data,
  output logic              tbl_wr_ack,
  output logic              busy
);

  localparam logic [CODE_W-1:0] LAST_IDX = ESC_CODE - CODE_W'(1);

  enc_state_t        state_reg;
  logic [SYM_W-1:0]  sym_reg;
  logic [CODE_W-1:0] idx_reg;
  logic              primed_reg;
  logic              code_valid_reg;
  logic [CODE_W-1:0] code_data_reg;
  logic              code_last_reg;
  logic              ack_reg;

  logic              wr_take;
  logic              accept;
  logic [SYM_W-1:0]  tbl_rd_data;
  logic              tbl_rd_valid;
  logic [CODE_W-1:0] cmp_idx;
  logic              hit;
  logic              cache_hit;
  logic [CODE_W-1:0] cache_code;

  assign wr_take = tbl_wr_en && !reset && (state_reg == IDLE) && (tbl_wr_addr != ESC_CODE);
  assign accept  = sym_valid && sym_ready;

  symbol_table u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_take),
    .wr_addr  (tbl_wr_addr),
    .wr_data  (tbl_wr_data),
    .rd_addr  (idx_reg),
    .rd_data  (tbl_rd_data),
    .rd_valid (tbl_rd_valid)
  );

  // Read data lags the address by one cycle, so the entry under test is idx-1.
  assign cmp_idx = idx_reg - CODE_W'(1);
  assign hit     = tbl_rd_valid && (tbl_rd_data == sym_reg);

`ifdef SYMENC_LAST_HIT_CACHE_EN
  logic [SYM_W-1:0]  cache_sym_reg;
  logic [CODE_W-1:0] cache_code_reg;
  logic              cache_valid_reg;

  // A write in the acceptance cycle may add a lower-index match, so it bypasses the cache.
  assign cache_hit  = cache_valid_reg && !wr_take && (cache_sym_reg == sym_data);
  assign cache_code = cache_code_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_reg <= 1'b0;
      cache_sym_reg   <= '0;
      cache_code_reg  <= '0;
    end else if (wr_take) begin
      cache_valid_reg <= 1'b0;
    end else if ((state_reg == SEARCH) && primed_reg && hit) begin
      cache_valid_reg <= 1'b1;
      cache_sym_reg   <= sym_reg;
      cache_code_reg  <= cmp_idx;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_code = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      sym_reg        <= '0;
      idx_reg        <= '0;
      primed_reg     <= 1'b0;
      code_valid_reg <= 1'b0;
      code_data_reg  <= '0;
      code_last_reg  <= 1'b0;
      ack_reg        <= 1'b0;
    end else begin
      ack_reg <= wr_take;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sym_reg    <= sym_data;
            idx_reg    <= '0;
            primed_reg <= 1'b0;
            if (cache_hit) begin
              state_reg      <= EMIT_CODE;
              code_valid_reg <= 1'b1;
              code_data_reg  <= cache_code;
              code_last_reg  <= 1'b1;
            end else begin
              state_reg <= SEARCH;
            end
          end
        end
        SEARCH: begin
          primed_reg <= 1'b1;
          idx_reg    <= idx_reg + CODE_W'(1);
          if (primed_reg) begin
            if (hit) begin
              state_reg      <= EMIT_CODE;
              code_valid_reg <= 1'b1;
              code_data_reg  <= cmp_idx;
              code_last_reg  <= 1'b1;
            end else if (cmp_idx == LAST_IDX) begin
              state_reg      <= EMIT_ESC;
              code_valid_reg <= 1'b1;
              code_data_reg  <= ESC_CODE;
              code_last_reg  <= 1'b0;
            end
          end
        end
        EMIT_CODE: begin
          if (code_ready) begin
            state_reg      <= IDLE;
            code_valid_reg <= 1'b0;
            code_last_reg  <= 1'b0;
          end
        end
        EMIT_ESC: begin
          if (code_ready) begin
            state_reg     <= EMIT_HI;
            code_data_reg <= sym_reg[SYM_W-1:CODE_W];
          end
        end
        EMIT_HI: begin
          if (code_ready) begin
            state_reg     <= EMIT_LO;
            code_data_reg <= sym_reg[CODE_W-1:0];
            code_last_reg <= 1'b1;
          end
        end
        EMIT_LO: begin
          if (code_ready) begin
            state_reg      <= IDLE;
            code_valid_reg <= 1'b0;
            code_last_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          code_valid_reg <= 1'b0;
          code_last_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign sym_ready  = (state_reg == IDLE) && !reset;
  assign busy       = (state_reg != IDLE);
  assign code_valid = code_valid_reg;
  assign code_data  = code_data_reg;
  assign code_last  = code_last_reg;
  assign tbl_wr_ack = ack_reg;

endmodule

// File: tb/tb_symbol_encoder.sv
// Directed plus randomized bench for symbol_encoder against a table/queue
// reference model (honours SYMENC_LAST_HIT_CACHE_EN when defined).
module tb_symbol_encoder;

  localparam logic [7:0] ESC = 8'hFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        sym_valid;
  logic        sym_ready;
  logic [15:0] sym_data;
  logic        code_valid;
  logic        code_ready;
  logic [7:0]  code_data;
  logic        code_last;
  logic        tbl_wr_en;
  logic [7:0]  tbl_wr_addr;
  logic [15:0] tbl_wr_data;
  logic        tbl_wr_ack;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: table contents and the last-hit cache.
  logic [15:0] m_data [256];
  bit          m_valid [256];
  bit          c_valid;
  logic [15:0] c_sym;
  logic [7:0]  c_code;

  logic [15:0] pool [8] = '{16'h1234, 16'hBEEF, 16'hCAFE, 16'h0000,
                            16'h7777, 16'hFFFF, 16'hA5A5, 16'h0102};

  symbol_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_data    (sym_data),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .code_data   (code_data),
    .code_last   (code_last),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
    .tbl_wr_ack  (tbl_wr_ack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    c_valid = 1'b0;
  endtask

  function automatic int lookup(input logic [15:0] s);
    for (int i = 0; i < int'(ESC); i++) begin
      if (m_valid[i] && m_data[i] == s) return i;
    end
    return -1;
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [15:0] d);
    if (a != ESC) begin
      m_data[a]  = d;
      m_valid[a] = 1'b1;
      c_valid    = 1'b0;
    end
  endtask

  task automatic write_entry(input logic [7:0] a, input logic [15:0] d);
    tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_data = d;
    tick();
    tbl_wr_en = 1'b0;
    chk("wr_ack", tbl_wr_ack, (a != ESC));
    model_write(a, d);
    tick();
    chk("wr_ack_pulse", tbl_wr_ack, 0);
    $display("write addr=%02h data=%04h ack_expected=%0d", a, d, (a != ESC));
  endtask

  task automatic send_symbol(input logic [15:0] s, input int stall, input bit with_wr,
                             input logic [7:0] wa, input logic [15:0] wd);
    logic [7:0] exp_beats[$];
    bit         exp_last[$];
    int         exp_lat;
    int         k;
    int         lat;
    chk("sym_ready", sym_ready, 1);
    sym_valid = 1'b1; sym_data = s; code_ready = 1'b0;
    if (with_wr) begin
      tbl_wr_en = 1'b1; tbl_wr_addr = wa; tbl_wr_data = wd;
    end
    tick();
    sym_valid = 1'b0; tbl_wr_en = 1'b0;
    if (with_wr) begin
      chk("wr_ack_same_cycle", tbl_wr_ack, (wa != ESC));
      model_write(wa, wd);
    end
    chk("busy_after_accept", busy, 1);
    if (c_valid && c_sym == s) begin
      exp_lat = 1;
      exp_beats.push_back(c_code); exp_last.push_back(1'b1);
    end else begin
      k = lookup(s);
      if (k >= 0) begin
        exp_lat = k + 2;
        exp_beats.push_back(8'(k)); exp_last.push_back(1'b1);
`ifdef SYMENC_LAST_HIT_CACHE_EN
        c_valid = 1'b1; c_sym = s; c_code = 8'(k);
`endif
      end else begin
        exp_lat = int'(ESC) + 1;
        exp_beats.push_back(ESC);     exp_last.push_back(1'b0);
        exp_beats.push_back(s[15:8]); exp_last.push_back(1'b0);
        exp_beats.push_back(s[7:0]);  exp_last.push_back(1'b1);
      end
    end
    // A write while busy must be dropped; address 0 with this symbol would otherwise win.
    tbl_wr_en = 1'b1; tbl_wr_addr = 8'h00; tbl_wr_data = s;
    lat = 0;
    do begin
      tick();
      tbl_wr_en = 1'b0;
      lat++;
      if (lat == 1) chk("busy_wr_dropped", tbl_wr_ack, 0);
    end while (code_valid !== 1'b1 && lat < 400);
    chk("latency", lat, exp_lat);
    $display("symbol %04h latency=%0d expected=%0d beats=%0d", s, lat, exp_lat, exp_beats.size());
    if (code_valid !== 1'b1) return;
    foreach (exp_beats[b]) begin
      for (int st = 0; st < stall; st++) begin
        chk("stall_valid", code_valid, 1);
        chk("stall_data", code_data, exp_beats[b]);
        chk("stall_last", code_last, exp_last[b]);
        tick();
      end
      chk("beat_valid", code_valid, 1);
      chk("beat_data", code_data, exp_beats[b]);
      chk("beat_last", code_last, exp_last[b]);
      code_ready = 1'b1;
      tick();
      code_ready = 1'b0;
    end
    chk("done_valid", code_valid, 0);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1; sym_valid = 1'b0; sym_data = '0; code_ready = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_sym_ready", sym_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_code_data", code_data, 0);
    chk("rst_code_last", code_last, 0);
    chk("rst_wr_ack", tbl_wr_ack, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_sym_ready", sym_ready, 1);
    tick();

    // Basic hit at index 5.
    write_entry(8'h00, 16'h1234);
    write_entry(8'h05, 16'hBEEF);
    send_symbol(16'hBEEF, 0, 1'b0, 8'h00, 16'h0000);

    // Unmapped symbol escapes.
    send_symbol(16'hCAFE, 0, 1'b0, 8'h00, 16'h0000);

    // Lowest index wins; escape address is never written.
    write_entry(8'h00, 16'h0000);
    write_entry(8'h03, 16'h1234);
    write_entry(8'h10, 16'h1234);
    send_symbol(16'h1234, 1, 1'b0, 8'h00, 16'h0000);
    write_entry(8'hFF, 16'hFFFF);
    send_symbol(16'hFFFF, 0, 1'b0, 8'h00, 16'h0000);

    // Back-pressure during the escape sequence.
    send_symbol(16'hCAFE, 5, 1'b0, 8'h00, 16'h0000);

    // Repeat symbol, then a write forces a fresh search.
    send_symbol(16'hBEEF, 0, 1'b0, 8'h00, 16'h0000);
    send_symbol(16'hBEEF, 0, 1'b0, 8'h00, 16'h0000);
    write_entry(8'h20, 16'h5555);
    send_symbol(16'hBEEF, 0, 1'b0, 8'h00, 16'h0000);

    // Write and symbol in the same IDLE cycle.
    send_symbol(16'h7777, 0, 1'b1, 8'h02, 16'h7777);

    // Reset in the middle of a search drops the symbol and empties the table.
    write_entry(8'h30, 16'h3030);
    chk("pre_mid_rst_ready", sym_ready, 1);
    sym_valid = 1'b1; sym_data = 16'h1234;
    tick();
    sym_valid = 1'b0;
    tick();
    chk("mid_search_busy", busy, 1);
    chk("mid_search_no_valid", code_valid, 0);
    reset = 1'b1;
    tick();
    tick();
    chk("mid_rst_sym_ready", sym_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_code_valid", code_valid, 0);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_no_beat", code_valid, 0);
    end
    $display("reset during search applied");
    send_symbol(16'h1234, 0, 1'b0, 8'h00, 16'h0000);

    // Randomized writes and symbols from a small pool so hits and misses mix.
    for (int it = 0; it < 24; it++) begin
      logic [7:0] a;
      if ($urandom_range(0, 1) == 1) begin
        a = ($urandom_range(0, 7) == 0) ? ESC : 8'($urandom_range(0, 40));
        write_entry(a, pool[$urandom_range(0, 7)]);
      end
      send_symbol(pool[$urandom_range(0, 7)], int'($urandom_range(0, 2)),
                  ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 12)),
                  pool[$urandom_range(0, 7)]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
